dff_write_arbiter: RTL

- Round-robin arbiter that shares one enable-gated N-bit dff register between R requesters.
- Drives the register's d and en inputs.
- Owns write ordering, fairness and bounded burst ownership.
- Sits directly in front of the dff instance; the register's q is not read by this block.

---
 rtl/dff_write_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/dff_write_arbiter.sv
// Round-robin write arbiter feeding one enable-gated N-bit dff from R requesters,
// with bounded burst ownership. Optional WR_COUNT_EN adds a saturating handshake counter.
module dff_write_arbiter #(
  parameter int N         = 32,
  parameter int R         = 4,
  parameter int MAX_BURST = 4,
  localparam int IW       = $clog2(R)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [R-1:0]   req,
  input  logic [R-1:0]   lock,
  input  logic [R*N-1:0] wdata,
  output logic [R-1:0]   gnt,
  output logic [N-1:0]   reg_d,
  output logic           reg_en,
  output logic [IW-1:0]  owner,
  output logic           busy
`ifdef WR_COUNT_EN
  ,
  output logic [15:0]    wr_count
`endif
);

  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t          state;
  state_t          state_nx;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   ptr_nx;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_nx;

  logic [IW-1:0]   pick;
  logic            pick_ok;
  logic [IW:0]     sum;
  logic            hs;
  logic [IW-1:0]   hs_idx;
  logic [N-1:0]    hs_data;

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] x);
    if (x == IW'(R - 1)) return '0;
    return x + IW'(1);
  endfunction

  // Handshake: requester i transfers when req[i] & gnt[i] at a rising edge;
  // req is a level held until then, gnt is combinational and never depends on it being taken.

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      ptr    <= '0;
      count  <= '0;
      reg_d  <= '0;
      reg_en <= 1'b0;
      owner  <= '0;
      busy   <= 1'b0;
    end else begin
      state  <= state_nx;
      ptr    <= ptr_nx;
      count  <= count_nx;
      reg_en <= hs;
      busy   <= (state_nx == BURST);
      if (hs) begin
        reg_d <= hs_data;
        owner <= hs_idx;
      end
    end
  end

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    count_nx = count;
    hs       = |(req & gnt);
    hs_idx   = (state == BURST) ? owner : pick;
    hs_data  = '0;
    for (int i = 0; i < R; i++) begin
      if (hs_idx == IW'(i)) hs_data = wdata[i*N +: N];
    end
    case (state)
      IDLE: begin
        if (hs) begin
          if (lock[pick] && (MAX_BURST > 1)) begin
            state_nx = BURST;
            count_nx = CW'(1);
          end else begin
            ptr_nx = wrap_inc(pick);
          end
        end
      end
      BURST: begin
        // The final capped or unlocked write still completes on the exit edge.
        if (!hs || !lock[owner] || (count == CW'(MAX_BURST - 1))) begin
          state_nx = IDLE;
          ptr_nx   = wrap_inc(owner);
          count_nx = '0;
        end else begin
          count_nx = count + CW'(1);
        end
      end
      default: begin
        state_nx = IDLE;
        count_nx = '0;
      end
    endcase
  end

  always_comb begin
    pick    = '0;
    pick_ok = 1'b0;
    sum     = '0;
    for (int k = 0; k < R; k++) begin
      sum = {1'b0, ptr} + (IW+1)'(k);
      if (sum >= (IW+1)'(R)) sum = sum - (IW+1)'(R);
      if (!pick_ok && req[sum[IW-1:0]]) begin
        pick_ok = 1'b1;
        pick    = sum[IW-1:0];
      end
    end
    gnt = '0;
    if (rst) begin
      if (state == BURST) gnt[owner] = req[owner];
      else if (pick_ok)   gnt[pick]  = 1'b1;
    end
  end

`ifdef WR_COUNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_count <= '0;
    end else if (hs && (wr_count != 16'hFFFF)) begin
      wr_count <= wr_count + 16'd1;
    end
  end
`endif

endmodule
